// File: rtl/rr_grant_mux.sv
// Round-robin arbiter and data mux across upstream bypass FIFOs.
// Winner is popped and captured into a 1-deep valid/ready output register.
module rr_grant_mux #(
  parameter int NUM_PORTS = 4,
  parameter int WIDTH     = 64
) (
  input  logic                       CLK,
  input  logic                       Reset_n,
  input  logic [NUM_PORTS-1:0]       i_Valid,
  input  logic [NUM_PORTS*WIDTH-1:0] i_Data,
  output logic [NUM_PORTS-1:0]       o_Grant,
  output logic                       o_Valid,
  output logic [WIDTH-1:0]           o_Data,
  output logic [$clog2(NUM_PORTS)-1:0] o_PortId,
  input  logic                       i_Ready
);

  localparam int PTR_W = $clog2(NUM_PORTS);

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] sel;
  logic [PTR_W-1:0] ptr_nxt;
  logic [WIDTH-1:0] data_sel;
  logic             found;
  logic             load;
  logic             gnt_any;

  assign load    = ~o_Valid | i_Ready;
  assign gnt_any = Reset_n & load & found;

  // First requester at or after ptr, wrapping.
  always_comb begin
    int p;
    p     = 0;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      p = int'(ptr) + i;
      if (p >= NUM_PORTS) p = p - NUM_PORTS;
      if (!found && i_Valid[PTR_W'(p)]) begin
        found = 1'b1;
        sel   = PTR_W'(p);
      end
    end
  end

  always_comb begin
    o_Grant = '0;
    if (gnt_any) o_Grant[sel] = 1'b1;
  end

  always_comb begin
    data_sel = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (sel == PTR_W'(k)) data_sel = i_Data[k*WIDTH +: WIDTH];
    end
  end

  assign ptr_nxt = (sel == PTR_W'(NUM_PORTS-1)) ? '0 : sel + 1'b1;

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      o_Valid  <= 1'b0;
      o_Data   <= '0;
      o_PortId <= '0;
      ptr      <= '0;
    end else if (gnt_any) begin
      o_Valid  <= 1'b1;
      o_Data   <= data_sel;
      o_PortId <= sel;
      ptr      <= ptr_nxt;
    end else if (i_Ready) begin
      o_Valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_grant_mux.sv
// Directed bench for rr_grant_mux: reset, single port, rotation,
// wrap/skip, backpressure, drain and mid-stream reset.
module tb_rr_grant_mux;

  localparam int N = 4;
  localparam int W = 8;

  logic           CLK;
  logic           Reset_n;
  logic [N-1:0]   i_Valid;
  logic [N*W-1:0] i_Data;
  logic [N-1:0]   o_Grant;
  logic           o_Valid;
  logic [W-1:0]   o_Data;
  logic [1:0]     o_PortId;
  logic           i_Ready;

  int checks;
  int errors;

  rr_grant_mux #(.NUM_PORTS(N), .WIDTH(W)) dut (
    .CLK      (CLK),
    .Reset_n  (Reset_n),
    .i_Valid  (i_Valid),
    .i_Data   (i_Data),
    .o_Grant  (o_Grant),
    .o_Valid  (o_Valid),
    .o_Data   (o_Data),
    .o_PortId (o_PortId),
    .i_Ready  (i_Ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic chk_out(input string tag, input logic v,
                         input logic [7:0] d, input logic [1:0] id);
    chk({tag, "_valid"}, 32'(o_Valid), 32'(v));
    chk({tag, "_data"}, 32'(o_Data), 32'(d));
    chk({tag, "_id"}, 32'(o_PortId), 32'(id));
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    Reset_n = 1'b0;
    i_Ready = 1'b1;
    i_Valid = 4'hF;
    // port3..port0
    i_Data  = {8'hD3, 8'hA5, 8'hB1, 8'hC0};

    // 1. reset
    #3;
    chk("rst_grant", 32'(o_Grant), 32'h0);
    chk_out("rst", 1'b0, 8'h00, 2'd0);
    tick();
    Reset_n = 1'b1;
    i_Valid = 4'h0;
    #1;
    chk("rel_grant", 32'(o_Grant), 32'h0);
    tick();
    chk_out("rel", 1'b0, 8'h00, 2'd0);

    // 2. single port 2
    i_Valid = 4'b0100;
    #1;
    chk("single_grant", 32'(o_Grant), 32'b0100);
    tick();
    chk_out("single", 1'b1, 8'hA5, 2'd2);

    // 5. wrap/skip, ptr=3
    i_Valid = 4'b0011;
    #1;
    chk("wrap_g0", 32'(o_Grant), 32'b0001);
    tick();
    chk_out("wrap_o0", 1'b1, 8'hC0, 2'd0);
    #1;
    chk("wrap_g1", 32'(o_Grant), 32'b0010);
    tick();
    chk_out("wrap_o1", 1'b1, 8'hB1, 2'd1);
    #1;
    chk("wrap_g2", 32'(o_Grant), 32'b0001);
    tick();
    chk_out("wrap_o2", 1'b1, 8'hC0, 2'd0);

    // grant port 3 so ptr wraps to 0
    i_Valid = 4'b1000;
    #1;
    chk("last_grant", 32'(o_Grant), 32'b1000);
    tick();
    chk_out("last", 1'b1, 8'hD3, 2'd3);

    // 3. full load rotation from ptr=0
    i_Valid = 4'hF;
    #1;
    chk("full_g0", 32'(o_Grant), 32'b0001);
    tick();
    chk_out("full_o0", 1'b1, 8'hC0, 2'd0);
    #1;
    chk("full_g1", 32'(o_Grant), 32'b0010);
    tick();
    chk_out("full_o1", 1'b1, 8'hB1, 2'd1);
    #1;
    chk("full_g2", 32'(o_Grant), 32'b0100);
    tick();
    chk_out("full_o2", 1'b1, 8'hA5, 2'd2);
    #1;
    chk("full_g3", 32'(o_Grant), 32'b1000);
    tick();
    chk_out("full_o3", 1'b1, 8'hD3, 2'd3);
    #1;
    chk("full_g4", 32'(o_Grant), 32'b0001);
    tick();
    chk_out("full_o4", 1'b1, 8'hC0, 2'd0);

    // 4. backpressure, ptr=1
    i_Ready = 1'b0;
    #1;
    chk("bp_g0", 32'(o_Grant), 32'h0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("bp_grant", 32'(o_Grant), 32'h0);
      chk_out("bp_hold", 1'b1, 8'hC0, 2'd0);
    end
    i_Ready = 1'b1;
    #1;
    chk("bp_release", 32'(o_Grant), 32'b0010);
    tick();
    chk_out("bp_after", 1'b1, 8'hB1, 2'd1);

    // drain without refill
    i_Valid = 4'h0;
    #1;
    chk("drain_grant", 32'(o_Grant), 32'h0);
    tick();
    chk_out("drain", 1'b0, 8'hB1, 2'd1);

    // 6. mid-stream reset, ptr=2
    i_Valid = 4'b0100;
    tick();
    chk_out("pre_rst", 1'b1, 8'hA5, 2'd2);
    i_Valid = 4'hF;
    i_Ready = 1'b0;
    #1;
    Reset_n = 1'b0;
    #1;
    chk("mrst_grant", 32'(o_Grant), 32'h0);
    chk_out("mrst", 1'b0, 8'h00, 2'd0);
    @(negedge CLK);
    Reset_n = 1'b1;
    i_Ready = 1'b1;
    #1;
    chk("post_rst_g", 32'(o_Grant), 32'b0001);
    tick();
    chk_out("post_rst", 1'b1, 8'hC0, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
